// File: rtl/ddr_responder_pkg.sv
// ddr_responder_pkg: command encodings, init states, error codes and
// timing/mode constants shared by the DDR responder and its timer.
package ddr_responder_pkg;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [3:0] {
    ST_PWRUP     = 4'd0,
    ST_WAIT_PRE  = 4'd1,
    ST_WAIT_EMR  = 4'd2,
    ST_WAIT_MR   = 4'd3,
    ST_WAIT_PRE2 = 4'd4,
    ST_WAIT_REF1 = 4'd5,
    ST_WAIT_REF2 = 4'd6,
    ST_WAIT_MR2  = 4'd7,
    ST_READY     = 4'd8
  } init_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SEQ      = 3'd1;
  localparam logic [2:0] ERR_TIMING   = 3'd2;
  localparam logic [2:0] ERR_CLOSED   = 3'd3;
  localparam logic [2:0] ERR_OPEN     = 3'd4;
  localparam logic [2:0] ERR_MODE     = 3'd5;
  localparam logic [2:0] ERR_REF_OPEN = 3'd6;

  localparam int T_PRE_GAP = 3;
  localparam int T_LMR_GAP = 2;
  localparam int T_RCD     = 3;

  localparam logic [2:0] MODE_CL2 = 3'b010;
  localparam logic [2:0] MODE_BL2 = 3'b001;

  function automatic logic mode_ok(input logic [12:0] a);
    return (a[6:4] == MODE_CL2) && (a[2:0] == MODE_BL2);
  endfunction

  function automatic init_e next_init(input init_e s);
    init_e n;
    n = s;
    case (s)
      ST_WAIT_PRE:  n = ST_WAIT_EMR;
      ST_WAIT_EMR:  n = ST_WAIT_MR;
      ST_WAIT_MR:   n = ST_WAIT_PRE2;
      ST_WAIT_PRE2: n = ST_WAIT_REF1;
      ST_WAIT_REF1: n = ST_WAIT_REF2;
      ST_WAIT_REF2: n = ST_WAIT_MR2;
      ST_WAIT_MR2:  n = ST_READY;
      default:      n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ddr_cmd_timer.sv
// ddr_cmd_timer: command-to-command spacing counters; flags a command
// that arrives before the previous one's minimum gap has elapsed.
module ddr_cmd_timer
  import ddr_responder_pkg::*;
#(
  parameter int T_RFC = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  cmd_e       cmd_i,
  input  logic [1:0] ba_i,
  input  logic       valid_i,
  input  logic       accept_i,
  output logic       viol_o
);

  logic [7:0] gap_q;
  logic [1:0] act_q [4];
  logic       rw;

  assign rw = (cmd_i == CMD_RD) || (cmd_i == CMD_WR);
  assign viol_o = valid_i &&
                  ((gap_q != 8'd0) || (rw && act_q[ba_i] != 2'd0));

  // Counters hold the remaining cycles until the gap is satisfied.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q <= 8'd0;
      for (int b = 0; b < 4; b++) act_q[b] <= 2'd0;
    end else begin
      if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
      for (int b = 0; b < 4; b++)
        if (act_q[b] != 2'd0) act_q[b] <= act_q[b] - 2'd1;
      if (accept_i) begin
        case (cmd_i)
          CMD_PRE: gap_q <= 8'(T_PRE_GAP - 1);
          CMD_LMR: gap_q <= 8'(T_LMR_GAP - 1);
          CMD_REF: gap_q <= 8'(T_RFC);
          CMD_ACT: act_q[ba_i] <= 2'(T_RCD - 1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ddr_responder.sv
// ddr_responder: behavioural DDR SDRAM device for controller bring-up;
// checks init order, spacing and bank state, serves 2-beat bursts.
module ddr_responder
  import ddr_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int T_RFC     = 10
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        sd_CKE,
  input  logic        sd_CS,
  input  logic        sd_RAS,
  input  logic        sd_CAS,
  input  logic        sd_WE,
  input  logic [1:0]  sd_BA,
  input  logic [12:0] sd_A,
  input  logic        sd_LDM,
  input  logic        sd_UDM,
  input  logic [31:0] wrBeats,
  output logic [31:0] rdBeats,
  output logic        rdValid,
  output logic        dqOe,
  output logic        initDone,
  output logic        protoErr,
  output logic [2:0]  errCode
);

  localparam int DEPTH = 1 << ADDR_BITS;
  typedef logic [ADDR_BITS-1:0] idx_t;

  logic [15:0] mem_q [DEPTH];
  init_e       st_q;
  logic [3:0]  open_q;
  logic [12:0] row_q [4];
  logic [12:0] mode_q;
  logic        wr_pend_q, rd1_q, rd2_q;
  idx_t        wr_idx_q, rd1_idx_q, rd2_idx_q;
  logic        init_q, perr_q;
  logic [2:0]  ecode_q;

  cmd_e        cmd;
  logic        live, step_ok, viol, accept;
  logic [2:0]  err;
  idx_t        cidx, wr_idx1, ra0, ra1;
  logic [15:0] old0, old1, nw0, nw1, rb0, rb1;

  assign cmd  = cmd_e'({sd_RAS, sd_CAS, sd_WE});
  assign live = sd_CKE && !sd_CS && (st_q != ST_PWRUP) &&
                (cmd != CMD_NOP) && (cmd != CMD_BST);
  assign cidx = {sd_BA, sd_A[ADDR_BITS-3:0]};

  ddr_cmd_timer #(.T_RFC(T_RFC)) u_timer (
    .clk_i    (clk133_p),
    .rst_i    (rst),
    .cmd_i    (cmd),
    .ba_i     (sd_BA),
    .valid_i  (live),
    .accept_i (accept),
    .viol_o   (viol)
  );

  always_comb begin
    step_ok = 1'b0;
    case (st_q)
      ST_WAIT_PRE, ST_WAIT_PRE2:
        step_ok = (cmd == CMD_PRE) && sd_A[10];
      ST_WAIT_EMR:
        step_ok = (cmd == CMD_LMR) && (sd_BA == 2'b01);
      ST_WAIT_MR, ST_WAIT_MR2:
        step_ok = (cmd == CMD_LMR) && (sd_BA == 2'b00);
      ST_WAIT_REF1, ST_WAIT_REF2:
        step_ok = (cmd == CMD_REF);
      ST_READY: step_ok = 1'b1;
      default:  step_ok = 1'b0;
    endcase
  end

  always_comb begin
    err = ERR_NONE;
    if (!live)
      err = ERR_NONE;
    else if (viol)
      err = ERR_TIMING;
    else if (!step_ok)
      err = ERR_SEQ;
    else if (cmd == CMD_ACT && open_q[sd_BA])
      err = ERR_OPEN;
    else if ((cmd == CMD_RD || cmd == CMD_WR) && !open_q[sd_BA])
      err = ERR_CLOSED;
    else if (cmd == CMD_REF && |open_q)
      err = ERR_REF_OPEN;
    else if (cmd == CMD_LMR && sd_BA == 2'b00 && !mode_ok(sd_A))
      err = ERR_MODE;
  end

  assign accept = live && (err == ERR_NONE);

  // Write data arrives one cycle after the command; masks keep old bytes.
  assign wr_idx1 = wr_idx_q ^ idx_t'(1);
  assign old0 = mem_q[wr_idx_q];
  assign old1 = mem_q[wr_idx1];
  assign nw0  = {sd_UDM ? old0[15:8] : wrBeats[15:8],
                 sd_LDM ? old0[7:0]  : wrBeats[7:0]};
  assign nw1  = {sd_UDM ? old1[15:8] : wrBeats[31:24],
                 sd_LDM ? old1[7:0]  : wrBeats[23:16]};

  always_ff @(posedge clk133_p) begin
    if (!rst && wr_pend_q) begin
      mem_q[wr_idx_q] <= nw0;
      mem_q[wr_idx1]  <= nw1;
    end
  end

  // Write-first: a commit landing in the read data cycle is forwarded.
  assign ra0 = rd2_idx_q;
  assign ra1 = rd2_idx_q ^ idx_t'(1);

  always_comb begin
    rb0 = mem_q[ra0];
    rb1 = mem_q[ra1];
    if (wr_pend_q) begin
      if (ra0 == wr_idx_q)     rb0 = nw0;
      else if (ra0 == wr_idx1) rb0 = nw1;
      if (ra1 == wr_idx_q)     rb1 = nw0;
      else if (ra1 == wr_idx1) rb1 = nw1;
    end
  end

  assign rdBeats  = rd2_q ? {rb1, rb0} : 32'd0;
  assign rdValid  = rd2_q;
  assign dqOe     = rd2_q;
  assign initDone = init_q;
  assign protoErr = perr_q;
  assign errCode  = ecode_q;

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      st_q      <= ST_PWRUP;
      open_q    <= 4'd0;
      for (int b = 0; b < 4; b++) row_q[b] <= 13'd0;
      mode_q    <= 13'd0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      rd1_q     <= 1'b0;
      rd1_idx_q <= '0;
      rd2_q     <= 1'b0;
      rd2_idx_q <= '0;
      init_q    <= 1'b0;
      perr_q    <= 1'b0;
      ecode_q   <= ERR_NONE;
    end else begin
      if (st_q == ST_PWRUP && sd_CKE)
        st_q <= ST_WAIT_PRE;
      else if (accept && st_q != ST_READY)
        st_q <= next_init(st_q);
      if (accept && st_q == ST_WAIT_MR2) init_q <= 1'b1;
      if (accept) begin
        case (cmd)
          CMD_ACT: begin
            open_q[sd_BA] <= 1'b1;
            row_q[sd_BA]  <= sd_A;
          end
          CMD_PRE: begin
            if (sd_A[10]) open_q <= 4'd0;
            else          open_q[sd_BA] <= 1'b0;
          end
          CMD_LMR: if (sd_BA == 2'b00) mode_q <= sd_A;
          default: ;
        endcase
      end
      wr_pend_q <= accept && (cmd == CMD_WR);
      wr_idx_q  <= cidx;
      rd1_q     <= accept && (cmd == CMD_RD);
      rd1_idx_q <= cidx;
      rd2_q     <= rd1_q;
      rd2_idx_q <= rd1_idx_q;
      if (err != ERR_NONE && !perr_q) begin
        perr_q  <= 1'b1;
        ecode_q <= err;
      end
    end
  end

endmodule
